// File: rtl/hwpe_stream_fifo_earlystall_param_if.sv
// Valid/ready stream carrying a data word and its byte strobes.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;

    modport source (output valid, output data, output strb, input ready);
    modport sink   (input valid, input data, input strb, output ready);
endinterface

// File: rtl/hwpe_stream_fifo_earlystall_param.sv
// Stream FIFO whose ready drops STALL_MARGIN entries before full, so beats
// already in flight when ready falls can still be absorbed.
module hwpe_stream_fifo_earlystall_param #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned STALL_MARGIN = 2,
    parameter int unsigned SIDECH_WIDTH = 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             clear_i,
    hwpe_stream_intf_stream.sink             push_i,
    hwpe_stream_intf_stream.source           pop_o,
    input  logic [SIDECH_WIDTH-1:0]          sidech_i,
    output logic [SIDECH_WIDTH-1:0]          sidech_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  count_o,
    output logic                             overflow_o
);

    localparam int unsigned STRB_WIDTH  = DATA_WIDTH / 8;
    localparam int unsigned ENTRY_WIDTH = SIDECH_WIDTH + DATA_WIDTH + STRB_WIDTH;
    localparam int unsigned CNT_WIDTH   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_WIDTH   = $clog2(FIFO_DEPTH);

    localparam logic [CNT_WIDTH-1:0] CNT_FULL  = CNT_WIDTH'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_STALL = CNT_WIDTH'(FIFO_DEPTH - STALL_MARGIN);
    localparam logic [PTR_WIDTH-1:0] PTR_LAST  = PTR_WIDTH'(FIFO_DEPTH - 1);

    logic [ENTRY_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [CNT_WIDTH-1:0]   cnt;
    logic [PTR_WIDTH-1:0]   wr_ptr;
    logic [PTR_WIDTH-1:0]   rd_ptr;
    logic                   overflow;
    logic                   pop_valid;
    logic                   pop_hs;
    logic                   push_acc;
    logic                   push_drop;
    logic [ENTRY_WIDTH-1:0] rd_entry;

    // Explicit wrap so non-power-of-two depths never index past the last entry.
    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_WIDTH'(1);
    endfunction

    assign pop_valid = (cnt != '0);
    assign pop_hs    = pop_valid & pop_o.ready;
    assign push_acc  = push_i.valid & ((cnt != CNT_FULL) | pop_hs);
    assign push_drop = push_i.valid & (cnt == CNT_FULL) & ~pop_hs;

    assign push_i.ready = (cnt < CNT_STALL);
    assign pop_o.valid  = pop_valid;
    assign rd_entry     = mem[rd_ptr];
    assign pop_o.strb   = pop_valid ? rd_entry[0 +: STRB_WIDTH] : '0;
    assign pop_o.data   = pop_valid ? rd_entry[STRB_WIDTH +: DATA_WIDTH] : '0;
    assign sidech_o     = pop_valid ? rd_entry[ENTRY_WIDTH-1 -: SIDECH_WIDTH] : '0;
    assign count_o      = cnt;
    assign overflow_o   = overflow;

    always_ff @(posedge clk_i) begin
        if (push_acc && !clear_i) begin
            mem[wr_ptr] <= {sidech_i, push_i.data, push_i.strb};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else if (clear_i) begin
            cnt      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_hs) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push_acc, pop_hs})
                2'b10:   cnt <= cnt + CNT_WIDTH'(1);
                2'b01:   cnt <= cnt - CNT_WIDTH'(1);
                default: cnt <= cnt;
            endcase
            if (push_drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hwpe_stream_fifo_earlystall_param.sv
// Bench for the early-stall FIFO: directed scenarios plus random traffic,
// compared against a queue model on a default and a depth-5 instance.
module tb_hwpe_stream_fifo_earlystall_param;

    localparam int DEPTH_A  = 8;
    localparam int MARGIN_A = 2;
    localparam int DEPTH_B  = 5;
    localparam int MARGIN_B = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       clear_a, clear_b;
    logic       side_a_in, side_b_in;
    logic       side_a_out, side_b_out;
    logic [3:0] count_a;
    logic [2:0] count_b;
    logic       ovf_a_out, ovf_b_out;

    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) push_a ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) pop_a ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) push_b ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) pop_b ();

    hwpe_stream_fifo_earlystall_param dut_a (
        .clk_i      (clk),
        .rst_i      (rst),
        .clear_i    (clear_a),
        .push_i     (push_a),
        .pop_o      (pop_a),
        .sidech_i   (side_a_in),
        .sidech_o   (side_a_out),
        .count_o    (count_a),
        .overflow_o (ovf_a_out)
    );

    hwpe_stream_fifo_earlystall_param #(
        .DATA_WIDTH   (32),
        .FIFO_DEPTH   (DEPTH_B),
        .STALL_MARGIN (MARGIN_B),
        .SIDECH_WIDTH (1)
    ) dut_b (
        .clk_i      (clk),
        .rst_i      (rst),
        .clear_i    (clear_b),
        .push_i     (push_b),
        .pop_o      (pop_b),
        .sidech_i   (side_b_in),
        .sidech_o   (side_b_out),
        .count_o    (count_b),
        .overflow_o (ovf_b_out)
    );

    // Reference model: each FIFO is a queue of {side, data, strb} beats.
    logic [36:0] qa[$];
    logic [36:0] qb[$];
    bit          ovf_a;
    bit          ovf_b;
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        int          n;
        logic [36:0] f;
        n = qa.size();
        f = (n > 0) ? qa[0] : 37'd0;
        check({tag, ".count"}, 64'(count_a), 64'(n));
        check({tag, ".ready"}, 64'(push_a.ready), 64'(n < DEPTH_A - MARGIN_A));
        check({tag, ".valid"}, 64'(pop_a.valid), 64'(n > 0));
        check({tag, ".data"}, 64'(pop_a.data), 64'(f[35:4]));
        check({tag, ".strb"}, 64'(pop_a.strb), 64'(f[3:0]));
        check({tag, ".side"}, 64'(side_a_out), 64'(f[36]));
        check({tag, ".ovf"}, 64'(ovf_a_out), 64'(ovf_a));
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [3:0] s,
                                 input logic sd, input logic rdy, input logic clr);
        int n;
        bit pop, acc, drop;
        push_a.valid = v;
        push_a.data  = d;
        push_a.strb  = s;
        side_a_in    = sd;
        pop_a.ready  = rdy;
        clear_a      = clr;
        n    = qa.size();
        pop  = (n > 0) && rdy;
        acc  = v && ((n < DEPTH_A) || pop);
        drop = v && (n == DEPTH_A) && !pop;
        @(posedge clk);
        if (clr) begin
            qa.delete();
            ovf_a = 0;
        end else begin
            if (pop) void'(qa.pop_front());
            if (acc) qa.push_back({sd, d, s});
            if (drop) ovf_a = 1;
        end
        #1;
    endtask

    task automatic checkOutputSmall(input string tag);
        int          n;
        logic [36:0] f;
        n = qb.size();
        f = (n > 0) ? qb[0] : 37'd0;
        check({tag, ".count"}, 64'(count_b), 64'(n));
        check({tag, ".ready"}, 64'(push_b.ready), 64'(n < DEPTH_B - MARGIN_B));
        check({tag, ".valid"}, 64'(pop_b.valid), 64'(n > 0));
        check({tag, ".data"}, 64'(pop_b.data), 64'(f[35:4]));
        check({tag, ".side"}, 64'(side_b_out), 64'(f[36]));
        check({tag, ".ovf"}, 64'(ovf_b_out), 64'(ovf_b));
    endtask

    task automatic applyStimulusSmall(input logic v, input logic [31:0] d, input logic sd,
                                      input logic rdy, input logic clr);
        int n;
        bit pop, acc, drop;
        push_b.valid = v;
        push_b.data  = d;
        push_b.strb  = 4'hF;
        side_b_in    = sd;
        pop_b.ready  = rdy;
        clear_b      = clr;
        n    = qb.size();
        pop  = (n > 0) && rdy;
        acc  = v && ((n < DEPTH_B) || pop);
        drop = v && (n == DEPTH_B) && !pop;
        @(posedge clk);
        if (clr) begin
            qb.delete();
            ovf_b = 0;
        end else begin
            if (pop) void'(qb.pop_front());
            if (acc) qb.push_back({sd, d, 4'hF});
            if (drop) ovf_b = 1;
        end
        #1;
    endtask

    initial begin
        int pushPct[4];
        int popPct[4];
        pushPct = '{90, 30, 70, 100};
        popPct  = '{30, 90, 70, 10};

        rst          = 1'b1;
        clear_a      = 1'b0;
        clear_b      = 1'b0;
        side_a_in    = 1'b0;
        side_b_in    = 1'b0;
        push_a.valid = 1'b0;
        push_a.data  = '0;
        push_a.strb  = '0;
        pop_a.ready  = 1'b0;
        push_b.valid = 1'b0;
        push_b.data  = '0;
        push_b.strb  = '0;
        pop_b.ready  = 1'b0;
        ovf_a        = 0;
        ovf_b        = 0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_a");
        checkOutputSmall("reset_b");
        rst = 1'b0;

        // Single beat into empty FIFO: visible next cycle, held while not popped
        applyStimulus(1'b1, 32'h5, 4'hF, 1'b1, 1'b0, 1'b0);
        checkOutput("lat");
        check("lat.valid_const", 64'(pop_a.valid), 64'd1);
        check("lat.data_const", 64'(pop_a.data), 64'h5);
        check("lat.side_const", 64'(side_a_out), 64'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
            checkOutput("hold");
            check("hold.data_const", 64'(pop_a.data), 64'h5);
        end
        applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("clear1");

        // Fill past the stall threshold to full, then overflow
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 32'(i), 4'hF, 1'b0, 1'b0, 1'b0);
            checkOutput("fill");
            if (i == 6) begin
                check("fill.ready_at6", 64'(push_a.ready), 64'd0);
            end
        end
        check("full.count_const", 64'(count_a), 64'd8);
        applyStimulus(1'b1, 32'h9, 4'hF, 1'b0, 1'b0, 1'b0);
        checkOutput("drop");
        check("drop.ovf_const", 64'(ovf_a_out), 64'd1);
        check("drop.count_const", 64'(count_a), 64'd8);

        // Push while full with a same-cycle pop is accepted
        applyStimulus(1'b1, 32'hAA, 4'hF, 1'b0, 1'b1, 1'b0);
        checkOutput("fullpp");
        check("fullpp.count_const", 64'(count_a), 64'd8);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
            checkOutput("drain4");
        end
        check("drain4.data_const", 64'(pop_a.data), 64'h6);

        // Clear overrides a same-cycle push
        applyStimulus(1'b1, 32'h33, 4'hF, 1'b1, 1'b0, 1'b1);
        checkOutput("clear2");
        check("clear2.count_const", 64'(count_a), 64'd0);
        check("clear2.ovf_const", 64'(ovf_a_out), 64'd0);
        check("clear2.data_const", 64'(pop_a.data), 64'd0);

        // Refill then drain, to confirm 0xAA-style ordering after clear
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 32'(16 + i), 4'(i), 1'(i), 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 32'hAA, 4'hF, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
            checkOutput("order");
            if (i == 6) check("order.aa_last", 64'(pop_a.data), 64'hAA);
        end

        // Random traffic in phases of different push/pop pressure
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 100; i++) begin
                applyStimulus(1'($urandom_range(0, 99) < pushPct[p]), $urandom,
                              4'($urandom), 1'($urandom),
                              1'($urandom_range(0, 99) < popPct[p]),
                              1'($urandom_range(0, 59) == 0));
                checkOutput("rand_a");
            end
        end

        // Asynchronous reset in the middle of a stream
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'(32'h100 + i), 4'hF, 1'b0, 1'b0, 1'b0);
        end
        push_a.valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        qa.delete();
        ovf_a = 0;
        qb.delete();
        ovf_b = 0;
        checkOutput("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b1, 32'h7, 4'hF, 1'b0, 1'b0, 1'b0);
        checkOutput("post_rst");
        check("post_rst.data_const", 64'(pop_a.data), 64'h7);
        applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("post_rst_pop");

        // Depth-5 instance: continuous push and pop across pointer wrap
        for (int i = 0; i < 20; i++) begin
            applyStimulusSmall(1'b1, 32'(i), 1'(i), 1'b1, 1'b0);
            checkOutputSmall("stream_b");
            check("stream_b.count_const", 64'(count_b), 64'd1);
            check("stream_b.data_const", 64'(pop_b.data), 64'(i));
        end
        applyStimulusSmall(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutputSmall("stream_b_end");
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 50; i++) begin
                applyStimulusSmall(1'($urandom_range(0, 99) < pushPct[p]), $urandom,
                                   1'($urandom),
                                   1'($urandom_range(0, 99) < popPct[p]),
                                   1'($urandom_range(0, 59) == 0));
                checkOutputSmall("rand_b");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
